// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding, the supported width limit and a helper
// that sizes the bit counter.
package serial_add_pkg;

    // Controller states: idle (accepting), running (one bit per cycle), done (result held)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest operand the controller is built for
    localparam int SERIAL_ADD_W_MAX = 64;

    // Bit counter width: enough to count 0..w-1, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : serial_add_pkg

// File: rtl/half_adder.sv
// 1-bit half adder: the basic arithmetic cell of the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry of two bits
    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder

// File: rtl/serial_full_adder.sv
// 1-bit full adder built from two half adders and an OR gate.
// Shared by every bit position of the serial adder, one bit per cycle.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    // First stage adds the operand bits
    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    // Second stage folds in the incoming carry
    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // At most one of the two stage carries can be set, so OR is enough
    assign cout = c0 | c1;

endmodule : serial_full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder controller.
// Accepts an operand pair over valid/ready, feeds one shared full-adder cell
// LSB-first for W cycles, then holds sum/cout under an output valid/ready
// handshake until the consumer takes them.
// Optional feature: define SERIAL_ADD_SUB_EN to add the 'sub' port, which
// selects a-b (b inverted, carry seeded with 1; cout=1 means no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = cnt_width(W);

    // Reject unsupported widths at elaboration
    generate
        if (W < 1 || W > SERIAL_ADD_W_MAX) begin : g_bad_width
            $error("serial_add_ctrl: W out of range 1..64");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_sr_q, a_sr_d;
    logic [W-1:0]    b_sr_q, b_sr_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    logic            sub_sel;
    logic            accept;
    logic            last_bit;
    logic            fa_s;
    logic            fa_c;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Operands are only taken while idle; the counter marks the final bit
    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign last_bit = (cnt_q == CW'(W - 1));

    // The one arithmetic cell, always looking at the current LSBs and carry
    serial_full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last bit, DONE -> IDLE on take
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

    // Datapath next values: load on accept, shift one bit per RUN cycle, hold otherwise
    always_comb begin
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        if (accept) begin
            a_sr_d  = a;
            // Subtraction is a + ~b + 1: invert b and seed the carry
            b_sr_d  = sub_sel ? ~b : b;
            carry_d = sub_sel;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            // New sum bit enters at the top; after W shifts bit 0 lands at bit 0
            sum_d   = (sum_q >> 1) | (W'(fa_s) << (W - 1));
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                cout_d = fa_c;
            end
        end
    end

    // Datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver pushes hand-computed
// results as it issues operands; a monitor compares whenever out_valid is up.
// Small W=1 and W=16 instances are checked directly at the end.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        bit           chk_gap;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub_t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    // W=1 instance
    logic         in_valid1, in_ready1, out_valid1, cout1;
    logic [0:0]   a1, b1, sum1;
    // W=16 instance
    logic         in_valid16, in_ready16, out_valid16, cout16;
    logic [15:0]  a16, b16, sum16;

    exp_t         sb_q[$];
    int           n_vec;
    int           n_fail;
    int           cyc;
    int           accept_edge;
    int           last_rise;
    bit           prev_valid;

    serial_add_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_t),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_add_ctrl #(.W(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (1'b1),
        .sum       (sum1),
        .cout      (cout1)
    );

    serial_add_ctrl #(.W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid16),
        .out_ready (1'b1),
        .sum       (sum16),
        .cout      (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the DUT result with the scoreboard head while out_valid is up
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) accept_edge = cyc + 1;
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_result: got sum=%h cout=%b, required none", sum, cout);
                end else begin
                    if (!prev_valid) begin
                        n_vec++;
                        if (cyc != accept_edge + W) begin
                            n_fail++;
                            $display("FAIL latency: got %0d cycles, required %0d", cyc - accept_edge, W);
                        end
                        if (sb_q[0].chk_gap) begin
                            n_vec++;
                            if (cyc - last_rise != W + 2) begin
                                n_fail++;
                                $display("FAIL b2b_spacing: got %0d, required %0d", cyc - last_rise, W + 2);
                            end
                        end
                        last_rise = cyc;
                    end
                    n_vec++;
                    if (sum !== sb_q[0].sum || cout !== sb_q[0].cout) begin
                        n_fail++;
                        $display("FAIL result: got sum=%h cout=%b, required sum=%h cout=%b",
                                 sum, cout, sb_q[0].sum, sb_q[0].cout);
                    end else begin
                        $display("result sum=%h cout=%b ok", sum, cout);
                    end
                    n_vec++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL in_ready_in_done: got %b, required 0", in_ready);
                    end
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic check1(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Present one operand pair, push its expected result, return after the accept edge
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic [W-1:0] es, input logic ec, input bit gap, input bit push);
        bit accepted;
        int n;
        a = av; b = bv; sub_t = sv; in_valid = 1'b1;
        if (push) sb_q.push_back('{es, ec, gap});
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else n++;
        end
        @(posedge clk); #1;
        if (!accepted) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    // Wait until every expected result has been consumed
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int n;
        int start;
        n_vec = 0; n_fail = 0; cyc = 0; accept_edge = 0; last_rise = 0; prev_valid = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub_t = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; in_valid16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_out_valid", 16'(out_valid), 16'h0);
        check1("reset_in_ready", 16'(in_ready), 16'h1);
        check1("reset_sum", 16'(sum), 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-RUN: abort, nothing may come out later
        send(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check1("abort_out_valid", 16'(out_valid), 16'h0);
        check1("abort_in_ready", 16'(in_ready), 16'h1);
        check1("abort_sum", 16'(sum), 16'h0);
        check1("abort_cout", 16'(cout), 16'h0);
        $display("reset mid-run applied");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        // Plain adds
        send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1); in_valid = 1'b0; drain();
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); in_valid = 1'b0; drain();
        send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1); in_valid = 1'b0; drain();

        // Backpressure: hold 5 cycles in DONE while the next pair waits on in_valid
        out_ready = 1'b0;
        send(8'h3C, 8'h0C, 1'b0, 8'h48, 1'b0, 1'b0, 1'b1);
        fork
            send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            begin
                n = 0;
                while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // Back-to-back: in_valid and out_ready held high across three pairs
        send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        send(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();

`ifdef SERIAL_ADD_SUB_EN
        send(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1); in_valid = 1'b0; drain();
        send(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1); in_valid = 1'b0; drain();
`endif

        // W=1: 1+1 -> sum 0, carry 1, one RUN cycle
        a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
        @(negedge clk);
        check1("w1_in_ready", 16'(in_ready1), 16'h1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        start = cyc;
        n = 0;
        @(negedge clk);
        while (!out_valid1 && n < 20) begin @(negedge clk); n++; end
        check1("w1_latency", 16'(cyc - start), 16'd1);
        check1("w1_sum", 16'(sum1), 16'h0);
        check1("w1_cout", 16'(cout1), 16'h1);
        $display("w1 sum=%h cout=%b", sum1, cout1);

        // W=16: 000F+0001 -> 0010, carry 0
        @(posedge clk); #1;
        a16 = 16'h000F; b16 = 16'h0001; in_valid16 = 1'b1;
        @(negedge clk);
        check1("w16_in_ready", 16'(in_ready16), 16'h1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        start = cyc;
        n = 0;
        @(negedge clk);
        while (!out_valid16 && n < 40) begin @(negedge clk); n++; end
        check1("w16_latency", 16'(cyc - start), 16'd16);
        check1("w16_sum", sum16, 16'h0010);
        check1("w16_cout", 16'(cout16), 16'h0);
        $display("w16 sum=%h cout=%b", sum16, cout16);

        repeat (12) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl
